// File: rtl/floppy_track_stream.sv
// floppy_track_stream: turns drive byte strobes and sector-window flags into
// the byte stream the FDC sees under the head (gap fill, ID field, sector data
// read from the buffer RAM, CRC-16). Every byte appears exactly 2 clk after
// the strobe that produced it.
// Optional FM recording support is enabled by defining FLOPPY_STREAM_FM_EN,
// which adds the fm input (FM presets and FF gap fill when fm=1).
module floppy_track_stream #(
    parameter logic [7:0]  GAP_BYTE = 8'h4E,
    parameter int unsigned ADDR_W   = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dclk_en,
    input  logic              ready,
    input  logic              sector_hdr,
    input  logic              sector_data,
    input  logic [6:0]        track,
    input  logic [4:0]        sector,
    input  logic              side,
    input  logic [1:0]        size_code,
`ifdef FLOPPY_STREAM_FM_EN
    input  logic              fm,
`endif
    output logic [ADDR_W-1:0] buf_addr,
    output logic              buf_rd,
    input  logic [7:0]        buf_data,
    output logic [7:0]        byte_out,
    output logic              byte_valid,
    output logic [1:0]        byte_kind
);

    // Buffer read: buf_rd is a single-cycle request with no backpressure;
    // buf_data is taken exactly one clock later, no handshake back.

    typedef enum logic [2:0] {
        ST_IDLE, ST_GAP, ST_HDR, ST_DATA, ST_CRC1, ST_CRC2
    } state_t;

    localparam logic [1:0] K_GAP  = 2'd0;
    localparam logic [1:0] K_ID   = 2'd1;
    localparam logic [1:0] K_DATA = 2'd2;
    localparam logic [1:0] K_CRC  = 2'd3;

    function automatic logic [15:0] crc_update(input logic [15:0] crc_in,
                                               input logic [7:0]  data);
        logic [15:0] c;
        c = crc_in ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction

    logic              fm_mode;
    logic [15:0]       id_preset, data_preset;
    logic [7:0]        gap_fill;

`ifdef FLOPPY_STREAM_FM_EN
    assign fm_mode = fm;
`else
    assign fm_mode = 1'b0;
`endif

    assign id_preset   = fm_mode ? 16'hEF21 : 16'hB230;
    assign data_preset = fm_mode ? 16'hBF84 : 16'hE295;
    assign gap_fill    = fm_mode ? 8'hFF : GAP_BYTE;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [15:0]       crc_q, crc_d;
    // stage 1: byte chosen at the strobe, resolved one clock later
    logic              pend_valid_q, pend_valid_d;
    logic [1:0]        pend_kind_q, pend_kind_d;
    logic [7:0]        pend_byte_q, pend_byte_d;
    logic              pend_buf_q, pend_buf_d;
    logic              pend_crc_q, pend_crc_d;
    // stage 2: registered stream outputs
    logic              out_valid_q, out_valid_d;
    logic [7:0]        out_byte_q, out_byte_d;
    logic [1:0]        out_kind_q, out_kind_d;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        stage_byte;
    logic              as_gap;

    // Next-state, byte selection and CRC bookkeeping for both pipeline stages
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        crc_d        = crc_q;
        pend_valid_d = 1'b0;
        pend_kind_d  = pend_kind_q;
        pend_byte_d  = pend_byte_q;
        pend_buf_d   = 1'b0;
        pend_crc_d   = 1'b0;
        out_valid_d  = 1'b0;
        out_byte_d   = out_byte_q;
        out_kind_d   = out_kind_q;
        rd_req       = 1'b0;
        rd_addr      = idx_q;
        stage_byte   = pend_buf_q ? buf_data : pend_byte_q;
        // a dropped ID window is handled exactly like a gap strobe
        as_gap       = (state_q == ST_GAP) || (state_q == ST_CRC2) ||
                       ((state_q == ST_HDR) && !sector_hdr);

        // stage 1 -> stage 2: resolve the byte, fold ID/data bytes into CRC
        if (pend_valid_q) begin
            out_valid_d = 1'b1;
            out_byte_d  = stage_byte;
            out_kind_d  = pend_kind_q;
            if (pend_crc_q) begin
                crc_d = crc_update(crc_q, stage_byte);
            end
        end

        if (dclk_en) begin
            pend_valid_d = 1'b1;
            if (state_q == ST_IDLE) begin
                pend_valid_d = 1'b0;
                state_d      = ST_GAP;
                idx_d        = '0;
            end else if (as_gap) begin
                if (sector_hdr) begin
                    state_d     = ST_HDR;
                    idx_d       = ADDR_W'(1);
                    crc_d       = id_preset;
                    pend_kind_d = K_ID;
                    pend_byte_d = {1'b0, track};
                    pend_crc_d  = 1'b1;
                end else if (sector_data) begin
                    state_d     = ST_DATA;
                    idx_d       = ADDR_W'(1);
                    crc_d       = data_preset;
                    rd_req      = 1'b1;
                    rd_addr     = '0;
                    pend_kind_d = K_DATA;
                    pend_buf_d  = 1'b1;
                    pend_crc_d  = 1'b1;
                end else begin
                    state_d     = ST_GAP;
                    idx_d       = '0;
                    pend_kind_d = K_GAP;
                    pend_byte_d = gap_fill;
                end
            end else if (state_q == ST_HDR) begin
                idx_d       = idx_q + ADDR_W'(1);
                pend_kind_d = K_ID;
                pend_crc_d  = 1'b1;
                case (idx_q[2:0])
                    3'd1:    pend_byte_d = {7'b0, side};
                    3'd2:    pend_byte_d = {3'b0, sector};
                    3'd3:    pend_byte_d = {6'b0, size_code};
                    3'd4: begin
                        pend_byte_d = crc_q[15:8];
                        pend_kind_d = K_CRC;
                        pend_crc_d  = 1'b0;
                    end
                    default: begin
                        pend_byte_d = crc_q[7:0];
                        pend_kind_d = K_CRC;
                        pend_crc_d  = 1'b0;
                        state_d     = ST_GAP;
                        idx_d       = '0;
                    end
                endcase
            end else if (state_q == ST_DATA) begin
                if (sector_data) begin
                    rd_req      = 1'b1;
                    idx_d       = idx_q + ADDR_W'(1);
                    pend_kind_d = K_DATA;
                    pend_buf_d  = 1'b1;
                    pend_crc_d  = 1'b1;
                end else begin
                    state_d     = ST_CRC1;
                    idx_d       = '0;
                    pend_kind_d = K_CRC;
                    pend_byte_d = crc_q[15:8];
                end
            end else begin
                // ST_CRC1: low CRC byte is always sent, whatever the flags say
                state_d     = ST_CRC2;
                pend_kind_d = K_CRC;
                pend_byte_d = crc_q[7:0];
            end
        end

        // losing the drive aborts everything, strobe or not
        if (!ready) begin
            state_d      = ST_IDLE;
            idx_d        = '0;
            crc_d        = 16'hFFFF;
            pend_valid_d = 1'b0;
            out_valid_d  = 1'b0;
            rd_req       = 1'b0;
        end
    end

    // State, counters, CRC and both pipeline stages
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            crc_q        <= 16'hFFFF;
            pend_valid_q <= 1'b0;
            pend_kind_q  <= 2'd0;
            pend_byte_q  <= 8'd0;
            pend_buf_q   <= 1'b0;
            pend_crc_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_byte_q   <= 8'd0;
            out_kind_q   <= 2'd0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            crc_q        <= crc_d;
            pend_valid_q <= pend_valid_d;
            pend_kind_q  <= pend_kind_d;
            pend_byte_q  <= pend_byte_d;
            pend_buf_q   <= pend_buf_d;
            pend_crc_q   <= pend_crc_d;
            out_valid_q  <= out_valid_d;
            out_byte_q   <= out_byte_d;
            out_kind_q   <= out_kind_d;
        end
    end

    assign buf_rd     = rd_req & ~reset;
    assign buf_addr   = reset ? '0 : rd_addr;
    assign byte_out   = out_byte_q;
    assign byte_valid = out_valid_q;
    assign byte_kind  = out_kind_q;

endmodule

// File: doc/floppy_track_stream.md
Name: floppy_track_stream

Overview:
- Consumes the virtual floppy drive's byte strobe and sector-window flags.
- Produces the serial byte stream the FDC core sees under the head: gap fill, ID field bytes, sector data fetched from the sector buffer RAM, and CRC-16 bytes.
- Sits directly downstream of the drive model and upstream of the FDC read logic.

Parameters:
- GAP_BYTE, 8'h4E, fill byte emitted outside ID/data fields (MFM).
- ADDR_W, 11, width of sector buffer address.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- dclk_en  in  1  one-cycle byte strobe from the drive; pulses are ≥3 clk apart.
- ready  in  1  drive selected, at speed, head settled.
- sector_hdr  in  1  ID-field window (6 byte times).
- sector_data  in  1  data-field window (sector_len byte times).
- track  in  7  track under head.
- sector  in  5  sector number under head.
- side  in  1  head select.
- size_code  in  2  N field (0=128 .. 3=1024).
- buf_addr  out  ADDR_W  byte address into sector buffer.
- buf_rd  out  1  one-cycle buffer read request.
- buf_data  in  8  buffer read data, valid exactly 1 clk after buf_rd.
- byte_out  out  8  stream byte.
- byte_valid  out  1  one-cycle strobe qualifying byte_out.
- byte_kind  out  2  0=gap, 1=ID, 2=data, 3=CRC.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0; crc 16'hFFFF.
- States: IDLE, GAP, HDR, DATA, CRC1, CRC2. All transitions occur only in dclk_en cycles (cycle T).
  - IDLE: no output. Enter GAP on dclk_en when ready=1.
  - ready=0 in any state, at any time: go to IDLE immediately (not gated by dclk_en); drop any in-flight byte; clear counters.
  - GAP: classify each dclk_en cycle.
    - sector_hdr=1 (wins if both flags high): enter HDR, idx=0, crc=16'hB230 (CRC of A1 A1 A1 FE).
    - sector_data=1: enter DATA, idx=0, crc=16'hE295 (CRC of A1 A1 A1 FB).
    - otherwise: emit GAP_BYTE.
  - HDR idx 0..3 emits {0,track}, {7'b0,side}, {3'b0,sector}, {6'b0,size_code}. track/sector/side/size_code are sampled at T of that byte. CRC is updated with each byte.
  - HDR idx 4,5 emits crc[15:8] then crc[7:0], kind=3. If sector_hdr drops earlier, the HDR byte sequence is abandoned and that dclk_en cycle is classified as in GAP.
  - DATA: at T, buf_addr=idx and buf_rd=1; at T+1 capture buf_data, update CRC, idx+1. idx wraps at 2^ADDR_W to 0.
  - DATA exit: the first dclk_en cycle with sector_data=0 enters CRC1 and emits crc[15:8]. The next dclk_en enters CRC2 and emits crc[7:0], then GAP. The CRC tail is always emitted, even if the drive re-enters gap early on index.
- Output timing: byte_out/byte_kind update and byte_valid pulses at T+2 for every byte kind (fixed 2-clk latency).
- CRC arithmetic: CCITT, poly 0x1021, MSB first, processed as byte-wise combinational update.
- reset mid-field: abort with no partial CRC output; buf_rd is never asserted while in reset.

Optional Feature:
- Macro FLOPPY_STREAM_FM_EN adds input port fm (1 bit).
- With the macro and fm=1:
  - ID preset = 16'hEF21 (CRC of FE alone).
  - Data preset = 16'hBF84 (CRC of FB alone).
  - Gap fill = 8'hFF.
- With the macro and fm=0, or without the macro (no fm port): MFM presets and GAP_BYTE are used.

Test Plan:
- ready=1, flags low, 10 dclk_en → 10 byte_valid pulses, each byte_out=8'h4E, kind=0, each exactly 2 clk after its strobe.
- 6-byte HDR window with track=5, side=0, sector=3, size_code=1 → 05 00 03 01 kind=1, then 2 CRC bytes kind=3 that match the bench CCITT model seeded with B230.
- 256-byte DATA window, buffer filled with addr[7:0] → buf_addr 0..255 with one buf_rd per strobe; bytes 00..FF kind=2; then 2 CRC bytes on the next two strobes matching the model seeded with E295; then 4E.
- ready deasserted mid-DATA at idx=100 → same-cycle entry to IDLE; no further byte_valid or buf_rd; when ready returns, stream resumes with gap and buf_addr restarts at 0.
- sector_hdr dropped after 3 bytes, then flags low → only 3 ID bytes emitted, no CRC bytes; next byte is 4E.
- Under FLOPPY_STREAM_FM_EN with fm=1: 1-byte DATA window containing 00 → CRC equals the model seeded with BF84; gap bytes are FF.
